// File: rtl/dca_matrix_load_row_packer_pkg.sv
// Shared widths, state encoding and sizing helpers for the matrix load row packer.
package dca_matrix_load_row_packer_pkg;

    localparam logic [1:0] DCA_PACKER_IDLE  = 2'd0;
    localparam logic [1:0] DCA_PACKER_PACK  = 2'd1;
    localparam logic [1:0] DCA_PACKER_DRAIN = 2'd2;

    function automatic int calc_bw_row(input int matrix_size, input int bw_scalar);
        return matrix_size * bw_scalar;
    endfunction

    function automatic int calc_bpr(input int bw_row, input int bw_beat);
        return bw_row / bw_beat;
    endfunction

    function automatic int calc_bw_idx(input int matrix_size);
        return $clog2(matrix_size) + 1;
    endfunction

    // Counter width that stays legal when only one value is needed.
    function automatic int calc_bw_cnt(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dca_matrix_load_row_packer_if.sv
// Command, beat and tensor-row channels of the row packer; slave is the packer side.
interface dca_matrix_load_row_packer_if
    import dca_matrix_load_row_packer_pkg::*;
#(
    parameter int BW_IDX  = 4,
    parameter int BW_BEAT = 32,
    parameter int BW_ROW  = 64
);
    logic              cmd_wvalid;
    logic              cmd_wready;
    logic [BW_IDX-1:0] cmd_num_row;
    logic [BW_IDX-1:0] cmd_num_col;

    logic               beat_wvalid;
    logic               beat_wready;
    logic [BW_BEAT-1:0] beat_wdata;

    logic              load_tensor_row_wvalid;
    logic              load_tensor_row_wready;
    logic              load_tensor_row_wlast;
    logic [BW_ROW-1:0] load_tensor_row_wdata;

    modport master (
        output cmd_wvalid, cmd_num_row, cmd_num_col,
        input  cmd_wready,
        output beat_wvalid, beat_wdata,
        input  beat_wready,
        input  load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
        output load_tensor_row_wready
    );

    modport slave (
        input  cmd_wvalid, cmd_num_row, cmd_num_col,
        output cmd_wready,
        input  beat_wvalid, beat_wdata,
        output beat_wready,
        output load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
        input  load_tensor_row_wready
    );

endinterface

// File: rtl/dca_matrix_load_row_packer_row_output_reg.sv
// One-entry valid/ready holding register, data visible the cycle after load;
// in_rdy = empty or draining this cycle, so load-while-drain runs without a bubble.
module dca_row_output_reg
    import dca_matrix_load_row_packer_pkg::*;
#(
    parameter int BW_DATA = 65
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               clear,
    input  logic               enable,
    input  logic               in_vld,
    input  logic [BW_DATA-1:0] in_dat,
    output logic               in_rdy,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [BW_DATA-1:0] out_dat
);

    logic               vld_q;
    logic [BW_DATA-1:0] dat_q;

    assign in_rdy  = !vld_q || out_rdy;
    assign out_vld = vld_q;
    assign out_dat = dat_q;

    // Data is kept after a drain; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (enable) begin
            if (in_vld) begin
                vld_q <= 1'b1;
                dat_q <= in_dat;
            end else if (out_rdy) begin
                vld_q <= 1'b0;
            end
        end
    end

    a_no_overwrite: assert property (@(posedge clk) disable iff (!rstnn || clear)
        (enable && in_vld) |-> in_rdy);

endmodule

// File: rtl/dca_matrix_load_row_packer.sv
// Packs LSU beats into tensor rows, row valid the cycle after its final beat; final beat stalls while
// the output row is held. DCA_LOAD_ROW_COL_MASK_EN zeroes elements at or beyond num_col.
module dca_matrix_load_row_packer
    import dca_matrix_load_row_packer_pkg::*;
#(
    parameter int MATRIX_SIZE      = 8,
    parameter int BW_TENSOR_SCALAR = 8,
    parameter int BW_BEAT          = 32
) (
    input  logic clk,
    input  logic rstnn,
    input  logic clear,
    input  logic enable,
    output logic busy,
    dca_matrix_load_row_packer_if.slave bus
);

    localparam int BW_ROW  = calc_bw_row(MATRIX_SIZE, BW_TENSOR_SCALAR);
    localparam int BPR     = calc_bpr(BW_ROW, BW_BEAT);
    localparam int BW_IDX  = calc_bw_idx(MATRIX_SIZE);
    localparam int BW_BCNT = calc_bw_cnt(BPR);

    localparam logic [BW_BCNT-1:0] LAST_BEAT = BW_BCNT'(BPR - 1);
    localparam logic [BW_BCNT-1:0] BCNT_ONE  = BW_BCNT'(1);
    localparam logic [BW_IDX-1:0]  IDX_ONE   = BW_IDX'(1);
    localparam logic [BW_IDX-1:0]  IDX_MAX   = BW_IDX'(MATRIX_SIZE);

    generate
        if ((BW_ROW % BW_BEAT) != 0 || BPR < 1) begin : g_bad_beat_width
            $error("row width must be a non-zero integer multiple of the beat width");
        end
    endgenerate

    logic [1:0]         state;
    logic [BW_BCNT-1:0] beat_cnt;
    logic [BW_IDX-1:0]  row_cnt;
    logic [BW_IDX-1:0]  num_row;
    logic [BW_ROW-1:0]  pack;

    logic              cmd_fire;
    logic              beat_fire;
    logic              row_done;
    logic              row_last;
    logic              out_free;
    logic              out_vld;
    logic [BW_ROW:0]   out_dat;
    logic [BW_ROW-1:0] row_assembled;
    logic [BW_ROW-1:0] row_masked;
    logic              row_drain;

    assign bus.cmd_wready  = enable && (state == DCA_PACKER_IDLE);
    assign bus.beat_wready = enable && (state == DCA_PACKER_PACK)
                           && ((beat_cnt != LAST_BEAT) || out_free);

    assign cmd_fire  = bus.cmd_wvalid && bus.cmd_wready;
    assign beat_fire = bus.beat_wvalid && bus.beat_wready;
    assign row_done  = beat_fire && (beat_cnt == LAST_BEAT);
    assign row_last  = (row_cnt == (num_row - IDX_ONE));
    assign row_drain = enable && out_vld && bus.load_tensor_row_wready;

    assign busy = (state != DCA_PACKER_IDLE) || out_vld;

    // The final beat always lands in the top slot, so it bypasses the packing register.
    always_comb begin
        row_assembled = pack;
        row_assembled[BW_ROW-1 -: BW_BEAT] = bus.beat_wdata;
    end

`ifdef DCA_LOAD_ROW_COL_MASK_EN
    logic [BW_IDX-1:0] num_col;

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            num_col <= '0;
        end else if (cmd_fire) begin
            num_col <= bus.cmd_num_col;
        end
    end

    always_comb begin
        row_masked = row_assembled;
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            if (BW_IDX'(j) >= num_col) begin
                row_masked[j*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = '0;
            end
        end
    end
`else
    logic col_unused;

    assign col_unused = ^bus.cmd_num_col;
    assign row_masked = row_assembled;
`endif

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            state    <= DCA_PACKER_IDLE;
            beat_cnt <= '0;
            row_cnt  <= '0;
            num_row  <= '0;
            pack     <= '0;
        end else if (enable) begin
            case (state)
                DCA_PACKER_IDLE: begin
                    if (cmd_fire) begin
                        num_row  <= bus.cmd_num_row;
                        beat_cnt <= '0;
                        row_cnt  <= '0;
                        if (bus.cmd_num_row != '0) begin
                            state <= DCA_PACKER_PACK;
                        end
                    end
                end
                DCA_PACKER_PACK: begin
                    if (beat_fire) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            row_cnt  <= row_cnt + IDX_ONE;
                            if (row_last) begin
                                state <= DCA_PACKER_DRAIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BCNT_ONE;
                        end
                    end
                end
                DCA_PACKER_DRAIN: begin
                    if (row_drain) begin
                        state <= DCA_PACKER_IDLE;
                    end
                end
                default: state <= DCA_PACKER_IDLE;
            endcase

            for (int k = 0; k < BPR; k++) begin
                if (beat_fire && (beat_cnt == BW_BCNT'(k))) begin
                    pack[k*BW_BEAT +: BW_BEAT] <= bus.beat_wdata;
                end
            end
        end
    end

    dca_row_output_reg #(
        .BW_DATA (BW_ROW + 1)
    ) u_row_output_reg (
        .clk     (clk),
        .rstnn   (rstnn),
        .clear   (clear),
        .enable  (enable),
        .in_vld  (row_done),
        .in_dat  ({row_last, row_masked}),
        .in_rdy  (out_free),
        .out_vld (out_vld),
        .out_rdy (bus.load_tensor_row_wready),
        .out_dat (out_dat)
    );

    assign bus.load_tensor_row_wvalid = out_vld;
    assign bus.load_tensor_row_wlast  = out_dat[BW_ROW];
    assign bus.load_tensor_row_wdata  = out_dat[BW_ROW-1:0];

    a_cmd_legal: assert property (@(posedge clk) disable iff (!rstnn || clear)
        cmd_fire |-> ((bus.cmd_num_row <= IDX_MAX) && (bus.cmd_num_col <= IDX_MAX)));

endmodule

// File: tb/tb_dca_matrix_load_row_packer.sv
// Randomized bench for the row packer: element-level reference model, scoreboard and hold checks.
module tb_dca_matrix_load_row_packer;

    localparam int MS     = 8;
    localparam int BW_ROW = 64;
    localparam int BPR    = 2;
    localparam int EPB    = 4;
    localparam int LIMIT  = 2000;

`ifdef DCA_LOAD_ROW_COL_MASK_EN
    localparam bit          MASK_ON  = 1'b1;
    localparam logic [63:0] MASK_EXP = 64'h000000FFFFFFFFFF;
`else
    localparam bit          MASK_ON  = 1'b0;
    localparam logic [63:0] MASK_EXP = 64'hFFFFFFFFFFFFFFFF;
`endif

    logic clk = 1'b0;
    logic rstnn, clear, enable, busy;

    dca_matrix_load_row_packer_if #(.BW_IDX(4), .BW_BEAT(32), .BW_ROW(BW_ROW)) bus ();

    dca_matrix_load_row_packer #(
        .MATRIX_SIZE(MS), .BW_TENSOR_SCALAR(8), .BW_BEAT(32)
    ) dut (
        .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [64:0] exp_q[$];
    logic [63:0] last_row;
    logic [7:0]  seq_byte;
    int g_mode, g_vld, g_rdy, g_en, g_hold, g_clr_after, g_gap;

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    bit mon_on = 1'b0;
    bit p_vld = 1'b0, p_hs = 1'b0, p_flush = 1'b1, p_last_hs = 1'b0, p_last = 1'b0;
    logic [63:0] p_dat = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            bit hs;
            bit exp_last;
            logic [64:0] e;
            exp_last = 1'b0;
            if (p_vld && !p_hs && !p_flush) begin
                chk("hold_vld", {64'd0, bus.load_tensor_row_wvalid}, 65'd1);
                chk("hold_dat", {1'b0, bus.load_tensor_row_wdata}, {1'b0, p_dat});
                chk("hold_last", {64'd0, bus.load_tensor_row_wlast}, {64'd0, p_last});
            end
            if (p_last_hs) chk("busy_after_last", {64'd0, busy}, 65'd0);
            hs = enable && rstnn && !clear && bus.load_tensor_row_wvalid && bus.load_tensor_row_wready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("row_extra", {64'd0, bus.load_tensor_row_wvalid}, 65'd0);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = e[64];
                    chk("row_dat", {1'b0, bus.load_tensor_row_wdata}, {1'b0, e[63:0]});
                    chk("row_last", {64'd0, bus.load_tensor_row_wlast}, {64'd0, e[64]});
                    last_row = bus.load_tensor_row_wdata;
                end
            end
            p_vld     = bus.load_tensor_row_wvalid;
            p_dat     = bus.load_tensor_row_wdata;
            p_last    = bus.load_tensor_row_wlast;
            p_hs      = hs;
            p_flush   = !rstnn || clear;
            p_last_hs = hs && exp_last;
        end
    end

    // Entered and left just after a rising edge.
    task automatic run_matrix(input int nr, input int nc);
        logic [31:0] beats[$];
        int nb, bi, cyc;
        bit cmd_done, busy_pend, cf, bf;
        nb = nr * BPR;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] b;
            b = '1;
            if (g_mode == 0) b = $urandom;
            else if (g_mode == 1) begin
                for (int k = 0; k < EPB; k++) begin
                    b[k*8 +: 8] = seq_byte;
                    seq_byte++;
                end
            end
            beats.push_back(b);
        end
        for (int r = 0; r < nr; r++) begin
            logic [64:0] e;
            e = '0;
            for (int j = 0; j < MS; j++) begin
                int el;
                logic [31:0] b;
                el = r * MS + j;
                b  = beats[el / EPB];
                if (!(MASK_ON && j >= nc)) e[j*8 +: 8] = b[(el % EPB)*8 +: 8];
            end
            e[64] = (r == nr - 1);
            exp_q.push_back(e);
        end
        bi = 0; cyc = 0; cmd_done = 0; busy_pend = 0;
        while (cyc < LIMIT) begin
            bus.cmd_wvalid  = !cmd_done && ($urandom_range(0, 99) < g_vld);
            bus.cmd_num_row = 4'(nr);
            bus.cmd_num_col = 4'(nc);
            bus.beat_wvalid = (bi < nb) && ($urandom_range(0, 99) < g_vld);
            bus.beat_wdata  = (bi < nb) ? beats[bi] : $urandom;
            bus.load_tensor_row_wready = (cyc >= g_hold) && ($urandom_range(0, 99) < g_rdy);
            enable = !(g_gap > 0 && cyc >= g_gap && cyc < g_gap + 4) && ($urandom_range(0, 99) < g_en);
            clear  = (g_clr_after > 0) && (bi == g_clr_after);
            if (clear) begin
                enable = 1'b1;
                bus.cmd_wvalid = 1'b0;
                bus.beat_wvalid = 1'b0;
                bus.load_tensor_row_wready = 1'b0;
            end
            @(negedge clk);
            cf = bus.cmd_wvalid && bus.cmd_wready;
            bf = bus.beat_wvalid && bus.beat_wready;
            if (!enable) begin
                chk("en0_cmd_rdy", {64'd0, bus.cmd_wready}, 65'd0);
                chk("en0_beat_rdy", {64'd0, bus.beat_wready}, 65'd0);
            end
            if (g_hold > 0 && cyc == g_hold - 1) begin
                chk("hold_beats", 65'(bi), 65'(2 * BPR - 1));
                chk("hold_beat_rdy", {64'd0, bus.beat_wready}, 65'd0);
            end
            if (busy_pend) begin
                chk("busy_after_cmd", {64'd0, busy}, {64'd0, nr != 0});
                busy_pend = 0;
            end
            if (clear) begin
                @(posedge clk); #1;
                clear = 1'b0;
                exp_q.delete();
                @(negedge clk);
                chk("clr_wvalid", {64'd0, bus.load_tensor_row_wvalid}, 65'd0);
                chk("clr_cmd_rdy", {64'd0, bus.cmd_wready}, 65'd1);
                chk("clr_busy", {64'd0, busy}, 65'd0);
                break;
            end
            if (cmd_done && bi == nb && !busy) break;
            @(posedge clk); #1;
            if (cf) begin cmd_done = 1; busy_pend = 1; end
            if (bf) bi++;
            cyc++;
        end
        if (cyc >= LIMIT) chk("timeout_cyc", 65'(cyc), 65'd0);
        @(posedge clk); #1;
        bus.cmd_wvalid = 1'b0;
        bus.beat_wvalid = 1'b0;
        bus.load_tensor_row_wready = 1'b0;
        enable = 1'b1;
    endtask

    task automatic set_mode(input int mode, input int v, input int r, input int e);
        g_mode = mode; g_vld = v; g_rdy = r; g_en = e;
        g_hold = 0; g_clr_after = 0; g_gap = 0;
    endtask

    initial begin
        rstnn = 1'b0; clear = 1'b0; enable = 1'b1; seq_byte = 8'h00; last_row = '0;
        bus.cmd_wvalid = 1'b0; bus.cmd_num_row = '0; bus.cmd_num_col = '0;
        bus.beat_wvalid = 1'b0; bus.beat_wdata = '0; bus.load_tensor_row_wready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstnn = 1'b1;
        @(negedge clk);
        chk("rst_cmd_rdy", {64'd0, bus.cmd_wready}, 65'd1);
        chk("rst_beat_rdy", {64'd0, bus.beat_wready}, 65'd0);
        chk("rst_wvalid", {64'd0, bus.load_tensor_row_wvalid}, 65'd0);
        chk("rst_wlast", {64'd0, bus.load_tensor_row_wlast}, 65'd0);
        chk("rst_wdata", {1'b0, bus.load_tensor_row_wdata}, 65'd0);
        chk("rst_busy", {64'd0, busy}, 65'd0);
        mon_on = 1'b1;
        @(posedge clk); #1;

        set_mode(1, 100, 100, 100);
        run_matrix(3, 8);
        chk("seq_row2", {1'b0, last_row}, {1'b0, 64'h1716151413121110});

        set_mode(1, 100, 100, 100); g_hold = 10;
        run_matrix(3, 8);

        set_mode(1, 100, 100, 100); g_clr_after = 3;
        run_matrix(8, 8);
        set_mode(0, 100, 100, 100);
        run_matrix(1, 8);

        set_mode(0, 100, 100, 100);
        run_matrix(0, 8);

        set_mode(2, 100, 100, 100);
        run_matrix(1, 5);
        chk("mask_row", {1'b0, last_row}, {1'b0, MASK_EXP});

        set_mode(1, 100, 100, 100); g_gap = 2;
        run_matrix(2, 8);

        for (int t = 0; t < 40; t++) begin
            set_mode(0, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(60, 100));
            run_matrix($urandom_range(0, MS), $urandom_range(0, MS));
        end

        chk("rows_left", 65'(exp_q.size()), 65'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dca_matrix_load_row_packer.md
Name: dca_matrix_load_row_packer

Overview:
- Upstream neighbour of the DCA matrix load path.
- Accepts a per-matrix load command, then narrow memory read beats from the LSU data channel.
- Packs the beats into full tensor rows and emits them on the load tensor-row write channel (wready/wvalid/wlast/wdata) that feeds the matrix load-to-register stage.
- Decouples beat arrival from row consumption with one packing register plus one output row register.

Parameters:
- MATRIX_SIZE, 8, elements per row and maximum rows per matrix.
- BW_TENSOR_SCALAR, 8, bits per element.
- BW_BEAT, 32, bits per input beat. BW_ROW (= MATRIX_SIZE*BW_TENSOR_SCALAR) must be an integer multiple of BW_BEAT; an elaboration error is raised otherwise.

Ports:
- clk  in  1  clock.
- rstnn  in  1  reset; synchronous, active-low.
- clear  in  1  synchronous soft clear, same effect as reset.
- enable  in  1  global stall when 0.
- busy  out  1  high when state is not IDLE or the output register is valid.
- cmd_wvalid  in  1  command valid.
- cmd_wready  out  1  command ready.
- cmd_num_row  in  BW_IDX=$clog2(MATRIX_SIZE)+1  number of rows in the matrix.
- cmd_num_col  in  BW_IDX  number of valid columns per row.
- beat_wvalid  in  1  beat valid.
- beat_wready  out  1  beat ready.
- beat_wdata  in  BW_BEAT  beat payload.
- load_tensor_row_wvalid  out  1  row valid.
- load_tensor_row_wready  in  1  row ready.
- load_tensor_row_wlast  out  1  last row of the matrix.
- load_tensor_row_wdata  out  BW_ROW  packed row.

Behaviour:
- Reset/clear values: state=IDLE; all counters 0; the packing and output registers are zero and invalid. Outputs after reset: cmd_wready=1 (when enable=1), beat_wready=0, load_tensor_row_wvalid=0, wlast=0, wdata=0, busy=0.
- Derived constants: BPR = BW_ROW/BW_BEAT beats per row.
- State IDLE:
  - cmd_wready = enable. A command handshake latches num_row and num_col.
  - If num_row != 0, go to PACK.
  - If num_row == 0, the command is consumed, no rows are emitted, and the state stays IDLE.
- State PACK:
  - Beat k (0..BPR-1) of the current row is written to pack[k*BW_BEAT +: BW_BEAT], so beat 0 is in the LSBs and element 0 is in the LSBs.
  - beat_wready = enable & (beat_cnt != BPR-1 | out_free). out_free = !out_valid | load_tensor_row_wready.
  - On acceptance of the final beat (beat_cnt == BPR-1):
    - The assembled row, including that beat, loads into the output register in the same edge.
    - out_valid is set; wlast = (row_cnt == num_row-1).
    - beat_cnt wraps to 0 and row_cnt increments.
  - When the last row has been loaded, go to DRAIN.
- State DRAIN: beat_wready=0. When the output row handshake completes, go to IDLE.
- Output channel:
  - wvalid, wdata and wlast are held stable until wready is sampled high.
  - A simultaneous drain and load in one cycle keeps wvalid=1 with the new row: full throughput of one row per BPR cycles, no bubble.
- Latency: a row appears on the output channel in the cycle after its final beat is accepted.
- Ordering: beats arriving before a command are not accepted (beat_wready=0 in IDLE). A new command is not accepted until DRAIN completes.
- enable=0:
  - No state, counter or register changes.
  - cmd_wready and beat_wready are forced to 0.
  - Row outputs hold their values; a row handshake is not counted.
- clear or rstnn mid-matrix: the partial row and any pending output row are discarded; return to IDLE on the next edge.
- cmd_num_row > MATRIX_SIZE or cmd_num_col > MATRIX_SIZE is illegal; this is covered by a simulation assertion only.

Optional Feature:
- DCA_LOAD_ROW_COL_MASK_EN defined: element j of each output row is forced to zero when j >= num_col. Masking is applied when the row loads into the output register, so there is no extra latency. num_col == 0 yields an all-zero row.
- Undefined: cmd_num_col is ignored and beat data passes through unmasked.

Decomposition:
- Shared package (header):
  - BW_ROW, BPR and BW_IDX derivations.
  - State encoding constants DCA_PACKER_IDLE=0, PACK=1, DRAIN=2.
- One natural sub-module: dca_row_output_reg, a one-entry valid/ready holding register with load-while-drain. It is reusable by the store side.

Test Plan (MATRIX_SIZE=8, scalar=8, BW_BEAT=32, BPR=2):
- cmd num_row=3 with continuous beats 0x03020100, 0x07060504, … and wready=1 -> three rows: 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110. wlast only on the third row. busy drops the cycle after the third handshake.
- Same command with load_tensor_row_wready=0 for 10 cycles -> beat_wready drops on beat 3 (the final beat of row 1). Row 0 is held stable. No beat is lost after wready rises.
- Assert clear after 3 beats of a num_row=8 matrix -> IDLE next cycle, wvalid=0, cmd_wready=1. A new num_row=1 command produces a row built only from new beats.
- cmd num_row=0 -> accepted in one cycle, no row emitted, busy stays 0.
- With DCA_LOAD_ROW_COL_MASK_EN, num_col=5, beats 0xFFFFFFFF ×2 -> row 0x000000FFFFFFFFFF. Without the macro -> 0xFFFFFFFFFFFFFFFF.
- Toggle enable=0 for 4 cycles mid-row -> no beat accepted and wdata unchanged; the sequence resumes identically afterwards.
